// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_port
// Description : Responder side of the core data-memory port. Byte-addressable
//               word RAM with lane writes and extended loads, a 64-bit
//               machine timer with compare interrupt, and a sticky
//               access-fault status/address register pair. Reads are
//               combinational; all state changes on the rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_port #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        irq,
    output logic        fault
);

    localparam int          c_idx_w     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] c_ram_bytes = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    localparam logic [2:0] c_off_mtime_lo = 3'd0;
    localparam logic [2:0] c_off_mtime_hi = 3'd1;
    localparam logic [2:0] c_off_cmp_lo   = 3'd2;
    localparam logic [2:0] c_off_cmp_hi   = 3'd3;
    localparam logic [2:0] c_off_fstat    = 3'd4;
    localparam logic [2:0] c_off_faddr    = 3'd5;

    // Storage and architectural registers
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [1:0]  r_fstat;
    logic [31:0] r_faddr;
    logic        r_irq;

    // Access decode
    logic               w_access;
    logic               w_in_ram;
    logic               w_in_mmio;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_f3_load_ok;
    logic               w_f3_store_ok;
    logic               w_f3_bad;
    logic               w_misaligned;
    logic               w_unmapped;
    logic               w_fault_now;
    logic               w_ok;
    logic               w_ram_sel;
    logic               w_ram_wr;
    logic               w_mmio_wr;
    logic [c_idx_w-1:0] w_idx;
    logic [2:0]         w_mmio_off;

    // Datapath
    logic [31:0] w_ram_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ram_load;
    logic [31:0] w_mmio_load;
    logic [3:0]  w_lane_en;
    logic [31:0] w_lane_data;
    logic [1:0]  w_fstat_set;
    logic [1:0]  w_fstat_clr;

    assign w_access   = MemRead | MemWrite;
    assign w_in_ram   = {1'b0, Mem_WrAddr} < c_ram_bytes;
    assign w_in_mmio  = (Mem_WrAddr[31:5] == MMIO_BASE[31:5]);
    assign w_idx      = Mem_WrAddr[c_idx_w+1:2];
    assign w_mmio_off = Mem_WrAddr[4:2];

    assign w_is_half     = (funct3 == c_f3_h) || (funct3 == c_f3_hu);
    assign w_is_word     = (funct3 == c_f3_w);
    assign w_f3_store_ok = (funct3 == c_f3_b) || (funct3 == c_f3_h) || (funct3 == c_f3_w);
    assign w_f3_load_ok  = w_f3_store_ok || (funct3 == c_f3_bu) || (funct3 == c_f3_hu);
    // A store with an unsigned-load size code has no meaning
    assign w_f3_bad      = !w_f3_load_ok || (MemWrite && !w_f3_store_ok);

    // Alignment is judged first so an access never raises both bits
    assign w_misaligned = w_access &&
                          ((w_is_half && Mem_WrAddr[0]) ||
                           (w_is_word && (Mem_WrAddr[1:0] != 2'b00)));
    assign w_unmapped   = w_access && !w_misaligned &&
                          (w_f3_bad || !(w_in_ram || w_in_mmio) ||
                           (w_in_mmio && (funct3 != c_f3_w)));
    assign w_fault_now  = w_misaligned || w_unmapped;

    assign w_ok      = w_access && !w_fault_now;
    assign w_ram_sel = w_ok && w_in_ram;
    assign w_ram_wr  = w_ram_sel && MemWrite;
    assign w_mmio_wr = w_ok && w_in_mmio && MemWrite;

    assign w_fstat_set = {w_unmapped, w_misaligned};
    assign w_fstat_clr = (w_mmio_wr && (w_mmio_off == c_off_fstat)) ? Mem_WrData[1:0] : 2'b00;

    assign w_ram_word = r_mem[w_idx];
    assign w_ld_byte  = w_ram_word[{Mem_WrAddr[1:0], 3'b000} +: 8];
    assign w_ld_half  = Mem_WrAddr[1] ? w_ram_word[31:16] : w_ram_word[15:0];

    // Lane enables and right-aligned store data replicated across lanes
    always_comb begin
        w_lane_en   = 4'b1111;
        w_lane_data = Mem_WrData;
        case (funct3[1:0])
            2'b00: begin
                w_lane_en   = 4'b0001 << Mem_WrAddr[1:0];
                w_lane_data = {4{Mem_WrData[7:0]}};
            end
            2'b01: begin
                w_lane_en   = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{Mem_WrData[15:0]}};
            end
            default: begin
                w_lane_en   = 4'b1111;
                w_lane_data = Mem_WrData;
            end
        endcase
    end

    // RAM load extension by access size
    always_comb begin
        w_ram_load = w_ram_word;
        case (funct3)
            c_f3_b:  w_ram_load = {{24{w_ld_byte[7]}}, w_ld_byte};
            c_f3_h:  w_ram_load = {{16{w_ld_half[15]}}, w_ld_half};
            c_f3_bu: w_ram_load = {24'd0, w_ld_byte};
            c_f3_hu: w_ram_load = {16'd0, w_ld_half};
            default: w_ram_load = w_ram_word;
        endcase
    end

    // MMIO register read mux; reserved words read as zero
    always_comb begin
        w_mmio_load = 32'd0;
        case (w_mmio_off)
            c_off_mtime_lo: w_mmio_load = r_mtime[31:0];
            c_off_mtime_hi: w_mmio_load = r_mtime[63:32];
            c_off_cmp_lo:   w_mmio_load = r_mtimecmp[31:0];
            c_off_cmp_hi:   w_mmio_load = r_mtimecmp[63:32];
            c_off_fstat:    w_mmio_load = {30'd0, r_fstat};
            c_off_faddr:    w_mmio_load = r_faddr;
            default:        w_mmio_load = 32'd0;
        endcase
    end

    // Load data is zero unless a non-faulting load is in progress
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && w_ok) begin
            ReadData = w_in_ram ? w_ram_load : w_mmio_load;
        end
    end

    // RAM lane writes; contents are not reset, but a store during reset is dropped
    always_ff @(posedge clk) begin
        if (w_ram_wr && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_en[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

    // Timer, compare, fault status/address and interrupt registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_fstat    <= 2'b00;
            r_faddr    <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            // A half written by software replaces the count; the low half
            // keeps counting when only the high half is written, without carry
            if (w_mmio_wr && (w_mmio_off == c_off_mtime_lo)) begin
                r_mtime <= {r_mtime[63:32], Mem_WrData};
            end else if (w_mmio_wr && (w_mmio_off == c_off_mtime_hi)) begin
                r_mtime <= {Mem_WrData, r_mtime[31:0] + 32'd1};
            end else begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_mmio_wr && (w_mmio_off == c_off_cmp_lo)) begin
                r_mtimecmp[31:0] <= Mem_WrData;
            end
            if (w_mmio_wr && (w_mmio_off == c_off_cmp_hi)) begin
                r_mtimecmp[63:32] <= Mem_WrData;
            end

            // A new fault wins over a simultaneous clear of the same bit
            r_fstat <= (r_fstat & ~w_fstat_clr) | w_fstat_set;

            // Only the first fault since the last clear records its address
            if (w_fault_now && (r_fstat == 2'b00)) begin
                r_faddr <= Mem_WrAddr;
            end

            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign irq   = r_irq;
    assign fault = |r_fstat;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_port
// Description : Self-checking bench for data_mem_port with directed scenarios
//               and randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_port;

    localparam int          c_ram_bytes = 4096;
    localparam logic [31:0] c_base      = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] Mem_WrAddr = 32'd0;
    logic [31:0] Mem_WrData = 32'd0;
    logic [31:0] ReadData;
    logic        irq;
    logic        fault;

    data_mem_port #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (32'h0000_F000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .irq        (irq),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_mem [0:c_ram_bytes-1];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [1:0]  m_fstat;
    logic [31:0] m_faddr;
    logic        m_irq;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_fstat = 2'b00;
        m_faddr = 32'd0;
        m_irq   = 1'b0;
    endtask

    // 0 = legal, 1 = misaligned, 2 = unmapped / bad size
    function automatic int m_class(input bit rd, input bit wr, input logic [2:0] f3,
                                   input logic [31:0] a);
        int size;
        bit valid;
        bit in_ram;
        bit in_mmio;
        if (!rd && !wr) return 0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size > 1 && (a % size) != 0) return 1;
        valid   = (size != 0) && !(wr && f3 >= 3'd4);
        in_ram  = a < c_ram_bytes;
        in_mmio = (a >= c_base) && (a < c_base + 32'd32);
        if (!valid || (!in_ram && !in_mmio) || (in_mmio && f3 != 3'd2)) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        v = 32'd0;
        if (a < c_ram_bytes) begin
            n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd2) ? 4 : 2;
            for (int i = 0; i < n; i++) v = v | (32'(m_mem[a + i]) << (8 * i));
            if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            return v;
        end
        case (a - c_base)
            32'h00: return m_mtime[31:0];
            32'h04: return m_mtime[63:32];
            32'h08: return m_cmp[31:0];
            32'h0C: return m_cmp[63:32];
            32'h10: return {30'd0, m_fstat};
            32'h14: return m_faddr;
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: entered and left at 1 time unit after a rising edge
    task automatic cycle(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int cls;
        int n;
        logic [63:0] mt_n;
        logic [63:0] cmp_n;
        logic [1:0]  fs_n;
        logic [31:0] fa_n;
        logic        irq_n;
        MemRead = rd; MemWrite = wr; funct3 = f3; Mem_WrAddr = a; Mem_WrData = d;
        @(negedge clk);
        cls = m_class(rd, wr, f3, a);
        last_rd = ReadData;
        check("rdata", ReadData, (rd && cls == 0) ? m_load(f3, a) : 32'd0);
        check("irq", irq, m_irq);
        check("fault", fault, m_fstat != 2'b00);
        irq_n = (m_mtime >= m_cmp);
        mt_n  = m_mtime + 64'd1;
        cmp_n = m_cmp;
        fs_n  = m_fstat;
        fa_n  = m_faddr;
        if (cls != 0 && m_fstat == 2'b00) fa_n = a;
        @(posedge clk);
        if (wr && cls == 0) begin
            if (a < c_ram_bytes) begin
                n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                for (int i = 0; i < n; i++) m_mem[a + i] = 8'(d >> (8 * i));
            end else begin
                case (a - c_base)
                    32'h00: mt_n = {m_mtime[63:32], d};
                    32'h04: mt_n = {d, m_mtime[31:0] + 32'd1};
                    32'h08: cmp_n[31:0] = d;
                    32'h0C: cmp_n[63:32] = d;
                    32'h10: fs_n = fs_n & ~d[1:0];
                    default: ;
                endcase
            end
        end
        if (cls == 1) fs_n[0] = 1'b1;
        if (cls == 2) fs_n[1] = 1'b1;
        m_mtime = mt_n; m_cmp = cmp_n; m_fstat = fs_n; m_faddr = fa_n; m_irq = irq_n;
        #1;
    endtask

    task automatic random_phase(input int cycles);
        int kind;
        bit rd;
        bit wr;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int k = 0; k < cycles; k++) begin
            kind = $urandom_range(0, 9);
            rd = $urandom_range(0, 1);
            wr = !rd;
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if (kind == 4) a = 32'(4092 + $urandom_range(0, 3));
            if (kind == 5 || kind == 6) begin
                a = c_base + 32'($urandom_range(0, 31));
                if ($urandom_range(0, 4) != 0) begin
                    f3 = 3'd2;
                    a[1:0] = 2'b00;
                end
            end
            if (kind == 7) a = $urandom | 32'h0001_0000;
            if (kind == 8) begin rd = 0; wr = 0; end
            if (kind == 9) begin rd = 1; wr = 1; end
            cycle(rd, wr, f3, a, $urandom);
        end
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #11;
        check("rst_irq", irq, 1'b0);
        check("rst_fault", fault, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset values through the MMIO window
        cycle(1, 0, 3'd2, c_base + 32'h0C, 0);
        check("rst_cmp_hi", last_rd, 32'hFFFF_FFFF);
        cycle(1, 0, 3'd2, c_base + 32'h10, 0);
        check("rst_fstat", last_rd, 32'd0);
        cycle(1, 0, 3'd2, c_base + 32'h14, 0);
        check("rst_faddr", last_rd, 32'd0);

        // Known contents for every RAM location the traffic touches
        for (int i = 0; i < 64; i++) cycle(0, 1, 3'd2, 32'(4 * i), 32'hA5C3_0000 + 32'(i * 77));
        cycle(0, 1, 3'd2, 32'd4092, 32'h8001_7FFE);

        // Byte/half extension
        cycle(0, 1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        cycle(1, 0, 3'd0, 32'h13, 0); check("lb", last_rd, 32'hFFFF_FFDE);
        cycle(1, 0, 3'd4, 32'h13, 0); check("lbu", last_rd, 32'h0000_00DE);
        cycle(1, 0, 3'd1, 32'h12, 0); check("lh", last_rd, 32'hFFFF_DEAD);
        cycle(1, 0, 3'd5, 32'h12, 0); check("lhu", last_rd, 32'h0000_DEAD);
        cycle(0, 1, 3'd0, 32'h11, 32'h0000_0055);
        cycle(1, 0, 3'd2, 32'h10, 0); check("sb_lw", last_rd, 32'hDEAD_55EF);

        // Fault capture, first address kept, write-1-to-clear
        cycle(1, 0, 3'd1, 32'h21, 0); check("mis_rd", last_rd, 32'd0);
        cycle(1, 0, 3'd2, c_base + 32'h10, 0); check("fstat_mis", last_rd, 32'd1);
        check("fault_mis", fault, 1'b1);
        cycle(1, 0, 3'd2, c_base + 32'h14, 0); check("faddr_first", last_rd, 32'h21);
        cycle(0, 1, 3'd2, c_base + 32'h30, 32'h1234);
        cycle(1, 0, 3'd2, c_base + 32'h10, 0); check("fstat_both", last_rd, 32'd3);
        cycle(1, 0, 3'd2, c_base + 32'h14, 0); check("faddr_kept", last_rd, 32'h21);
        cycle(0, 1, 3'd2, c_base + 32'h10, 32'd3);
        check("fault_clr", fault, 1'b0);

        // mtime half writes and carry
        cycle(0, 1, 3'd2, c_base + 32'h04, 32'd0);
        cycle(0, 1, 3'd2, c_base + 32'h00, 32'hFFFF_FFFF);
        cycle(0, 0, 3'd0, 0, 0);
        cycle(1, 0, 3'd2, c_base + 32'h04, 0); check("mtime_hi", last_rd, 32'd1);
        cycle(1, 0, 3'd2, c_base + 32'h00, 0); check("mtime_lo", last_rd, 32'd1);

        // Bad size to MMIO and out-of-range load
        cycle(0, 1, 3'd0, c_base + 32'h08, 32'h0000_0011);
        cycle(1, 0, 3'd2, 32'h0002_0000, 0); check("unmapped_rd", last_rd, 32'd0);
        cycle(1, 0, 3'd2, c_base + 32'h08, 0); check("cmp_unchanged", last_rd, 32'hFFFF_FFFF);
        cycle(1, 0, 3'd2, c_base + 32'h10, 0); check("fstat_unm", last_rd, 32'd2);

        // Compare interrupt timing after a fresh reset
        #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        cycle(0, 1, 3'd2, c_base + 32'h08, 32'd20);
        cycle(0, 1, 3'd2, c_base + 32'h0C, 32'd0);
        for (int i = 0; i < 40 && m_mtime != 64'd20; i++) cycle(0, 0, 3'd0, 0, 0);
        check("mtime_at_20", m_mtime, 64'd20);
        check("irq_before", irq, 1'b0);
        cycle(0, 0, 3'd0, 0, 0);
        check("irq_rise", irq, 1'b1);

        // Asynchronous reset with irq and fault both active, store in flight
        cycle(1, 0, 3'd1, 32'h21, 0);
        check("pre_rst_fault", fault, 1'b1);
        check("pre_rst_irq", irq, 1'b1);
        MemRead = 0; MemWrite = 1; funct3 = 3'd2; Mem_WrAddr = 32'h40; Mem_WrData = 32'h1234_5678;
        #2 reset = 1'b1;
        #1;
        check("async_irq", irq, 1'b0);
        check("async_fault", fault, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        cycle(1, 0, 3'd2, c_base + 32'h00, 0); check("async_mtime", last_rd, 32'd0);
        cycle(1, 0, 3'd2, 32'h40, 0);

        random_phase(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
